// File: rtl/excess3_decoder_if.sv
// Excess-3 digit input and binary word output handshake bundle.
// The producer/sink side uses master; the decoder uses slave.
interface excess3_decoder_if #(
  parameter int OUT_W = 14,
  parameter int CW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_value;
  logic [1:0]       out_err;
  logic [CW-1:0]    out_ndig;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_err, out_ndig
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_value, out_err, out_ndig
  );
endinterface

// File: rtl/excess3_decoder.sv
// Accumulates MSB-first excess-3 digits into a binary word; result valid one cycle after the last accept.
// in_ready is low while a finished word waits for out_ready; the 7-segment output shows the last accepted digit.
module excess3_decoder #(
  parameter int NDIGITS = 4,
  parameter int OUT_W   = 14,
  parameter int CW      = $clog2(NDIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  excess3_decoder_if.slave    bus,
  output logic [6:0]          seg
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned MAX_VAL  = pow10(NDIGITS) - 64'd1;
  localparam longint unsigned OUT_SPAN = 64'd1 << OUT_W;

  generate
    if (OUT_SPAN <= MAX_VAL) begin : g_width_check
      $error("excess3_decoder: OUT_W too narrow for NDIGITS decimal digits");
    end
  endgenerate

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Active-low {a,b,c,d,e,f,g}; anything outside 0..9 or an invalid code blanks the display.
  function automatic logic [6:0] seg_pat(input logic ok, input logic [3:0] d);
    logic [6:0] p;
    p = 7'b1111111;
    if (ok) begin
      case (d)
        4'd0:    p = 7'b0000001;
        4'd1:    p = 7'b1001111;
        4'd2:    p = 7'b0010010;
        4'd3:    p = 7'b0000110;
        4'd4:    p = 7'b1001100;
        4'd5:    p = 7'b0100100;
        4'd6:    p = 7'b1100000;
        4'd7:    p = 7'b0001111;
        4'd8:    p = 7'b0000000;
        4'd9:    p = 7'b0001100;
        default: p = 7'b1111111;
      endcase
    end
    return p;
  endfunction

  state_t           r_state;
  logic [OUT_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_err;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_value;
  logic [1:0]       r_out_err;
  logic [CW-1:0]    r_out_ndig;
  logic [6:0]       r_seg;

  logic             w_code_ok;
  logic [3:0]       w_d;
  logic [OUT_W-1:0] w_acc_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_full;
  logic             w_final;
  logic [1:0]       w_err_next;
  logic [6:0]       w_seg_next;

  assign w_code_ok  = (bus.in_digit >= 4'd3) && (bus.in_digit <= 4'd12);
  assign w_d        = w_code_ok ? (bus.in_digit - 4'd3) : 4'd0;
  // acc*10 as shift-add; the width check above guarantees it cannot overflow.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + OUT_W'(w_d);
  assign w_cnt_next = r_cnt + CW'(1);
  assign w_full     = (w_cnt_next == CW'(NDIGITS));
  assign w_final    = bus.in_last | w_full;
  assign w_err_next = {r_err[1] | (w_full & ~bus.in_last), r_err[0] | ~w_code_ok};
  assign w_seg_next = seg_pat(w_code_ok, w_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= '0;
      r_out_valid <= 1'b0;
      r_out_value <= '0;
      r_out_err   <= '0;
      r_out_ndig  <= '0;
      r_seg       <= 7'b1111111;
    end else begin
      case (r_state)
        ACC: begin
          if (bus.in_valid) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_err <= w_err_next;
            r_seg <= w_seg_next;
            if (w_final) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_out_value <= w_acc_next;
              r_out_err   <= w_err_next;
              r_out_ndig  <= w_cnt_next;
            end
          end
        end
        DONE: begin
          // Result fields stay as-is after the handshake; only the word state is cleared.
          if (r_out_valid && bus.out_ready) begin
            r_state     <= ACC;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= '0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ACC);
  assign bus.out_valid = r_out_valid;
  assign bus.out_value = r_out_value;
  assign bus.out_err   = r_out_err;
  assign bus.out_ndig  = r_out_ndig;
  assign seg           = r_seg;

endmodule

// File: doc/excess3_decoder.md
Name: excess3_decoder

Overview:
- Receives a stream of excess-3 coded decimal digits, most significant first, over a valid/ready handshake.
- Validates each code, subtracts the bias of 3, and accumulates the unsigned binary value: value = value*10 + digit.
- Presents the finished word on a held valid/ready output port.
- Drives an active-low 7-segment display (a..g) showing the last decoded digit.
- Sits on the receive side of the team's binary-to-excess-3 display path, turning excess-3 traffic back into binary.

Parameters:
- NDIGITS, 4, maximum decimal digits per word.
- OUT_W, 14, width of the binary result. Must satisfy 2^OUT_W > 10^NDIGITS - 1; elaboration error otherwise.
- CW, $clog2(NDIGITS+1), width of the digit count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_digit/in_last valid.
- in_ready  out  1  block accepts a digit this cycle.
- in_digit  in  4  excess-3 code.
- in_last  in  1  marks final digit of the word.
- out_valid  out  1  result word valid.
- out_ready  in  1  sink accepts the result.
- out_value  out  OUT_W  binary result.
- out_err  out  2  bit0 = invalid code seen; bit1 = word cut at NDIGITS without in_last.
- out_ndig  out  CW  digits accepted in the word.
- seg  out  7  {a,b,c,d,e,f,g}, active low.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high. All state is registered.
- Reset values: state=ACC, acc=0, cnt=0, err=0, out_valid=0, out_value=0, out_err=0, out_ndig=0, seg=7'b1111111 (blank).
- Reset mid-word or while in DONE discards everything. in_ready=1 on the first cycle after reset deasserts.
- States: ACC and DONE. in_ready = (state==ACC), decoded from the state register only, with no combinational path from inputs.
- Accept in ACC: in_valid & in_ready. On each accept:
  - code valid when 3 <= in_digit <= 12; d = in_digit - 3.
  - invalid codes 0000, 0001, 0010, 1101, 1110, 1111: d = 0, set err[0] (sticky for the word).
  - acc <= acc*10 + d, computed in OUT_W bits (no overflow, given the parameter constraint).
  - cnt <= cnt + 1.
- Termination: the accept is final if in_last=1 or cnt+1==NDIGITS.
  - If the word ends at NDIGITS without in_last, set err[1].
  - If in_last arrives exactly on the NDIGITS-th digit, err[1]=0.
- ACC->DONE on a final accept. On the following edge the block registers:
  - out_value = new acc, out_ndig = cnt+1, out_err = accumulated err, out_valid = 1.
  - Latency: out_valid rises one cycle after the last-digit accept cycle.
- DONE: in_ready=0. out_valid, out_value, out_err and out_ndig are held stable until out_ready=1.
- DONE->ACC on out_valid & out_ready. Same edge: out_valid<=0, acc<=0, cnt<=0, err<=0. out_value/out_err/out_ndig keep their last values. in_ready=1 next cycle; no input accept in the handshake cycle.
- in_last with in_valid=0 is ignored. A single-digit word (in_last on first digit) is legal: out_ndig=1.
- Display: seg updates on every accept, not on every cycle.
  - d 0..9 patterns: 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:1100000, 7:0001111, 8:0000000, 9:0001100.
  - Invalid code: 1111111.
  - seg holds through DONE and across words until the next accept.

Test Plan:
- Reset, then codes 0111, 1010, 0101 (last on the third) on consecutive cycles -> out_valid one cycle after the third accept; out_value=472 (0x1D8), out_err=00, out_ndig=3, seg=0010010.
- Codes 0100, 1101, 0100 (last) -> out_value=101, out_err=01, out_ndig=3; seg=1111111 after the second digit, 1001111 after the third.
- NDIGITS=4, codes 0100, 0101, 0110, 0111 with in_last=0 -> out_value=1234, out_err=10, out_ndig=4. A fifth digit presented is stalled (in_ready=0) until the out handshake, then becomes the first digit of the next word.
- After a word completes, hold out_ready=0 for 5 cycles -> out_valid and out_value stable, in_ready=0 throughout. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Random in_valid gaps on the word 1000, 0011 (last) -> out_value=50, matching the gap-free result.
- Assert rst after two digits of a word -> all outputs at reset values next cycle. A following word 1100 (last) -> out_value=9, out_ndig=1, out_err=00.
